// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game controller and its datapath.
//   state_e        : 3-bit controller state encoding
//   min_width(n)   : bits needed to index n items, never less than 1
package genius_pkg;

  typedef enum logic [2:0] {
    StInit      = 3'd0,
    StSetup     = 3'd1,
    StPlayFpga  = 3'd2,
    StPlayUser  = 3'd3,
    StCheck     = 3'd4,
    StNextRound = 3'd5,
    StRetry     = 3'd6,
    StResult    = 3'd7
  } state_e;

  function automatic int unsigned min_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/genius_timer.sv
// User-response timeout counter.
//   clock_50 : clock (rising edge)
//   reset    : synchronous, active-low
//   run      : counting enabled; the count is held at zero while low
//   restart  : clears the count (user key activity)
//   expire   : high in the cycle the count reaches TIMEOUT_CYCLES-1 with no restart
module genius_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic clock_50,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;

  assign expire = run && !restart && (count_q == LastCnt);

  always_comb begin
    count_d = count_q;
    if (!run || restart) begin
      count_d = '0;
    end else if (count_q != LastCnt) begin
      // Saturate so the counter can never wrap back into a fresh window
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clock_50) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/genius_controle.sv
// Genius game controller: sequences setup, FPGA playback, user entry, check,
// round advance and result; owns round, player, lives and timeout state.
//   clock_50, reset                 : clock and synchronous active-low reset
//   enter, end_fpga, end_user, key  : game control inputs from buttons/datapath
//   match, practice                 : compare result, practice mode select
//   r1, r2, e1..e4, sel             : Moore strobes to the datapaths
//   round, player, lives            : game progress
//   time_up                         : one-cycle timeout pulse
//   won                             : outcome, valid in RESULT
module genius_controle
  import genius_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS     = 32,
  parameter int unsigned N_PLAYERS      = 1,
  parameter int unsigned MAX_LIVES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  localparam int unsigned ROUND_W  = $clog2(MAX_ROUNDS + 1),
  localparam int unsigned PLAYER_W = min_width(N_PLAYERS),
  localparam int unsigned LIFE_W   = $clog2(MAX_LIVES + 1)
) (
  input  logic                clock_50,
  input  logic                reset,
  input  logic                enter,
  input  logic                end_fpga,
  input  logic                end_user,
  input  logic                key,
  input  logic                match,
  input  logic                practice,
  output logic                r1,
  output logic                r2,
  output logic                e1,
  output logic                e2,
  output logic                e3,
  output logic                e4,
  output logic                sel,
  output logic [ROUND_W-1:0]  round,
  output logic [PLAYER_W-1:0] player,
  output logic [LIFE_W-1:0]   lives,
  output logic                time_up,
  output logic                won
);

  state_e              state_q, state_d;
  logic [ROUND_W-1:0]  round_q, round_d;
  logic [PLAYER_W-1:0] player_q, player_d;
  logic [LIFE_W-1:0]   lives_q, lives_d;
  logic                won_q, won_d;
  logic                mode_q, mode_d;
  logic                timer_run, expire, fail;

  assign timer_run = (state_q == StPlayUser);

  genius_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock_50(clock_50),
    .reset   (reset),
    .run     (timer_run),
    .restart (key),
    .expire  (expire)
  );

  // A completed entry outranks an expiry landing in the same cycle
  assign time_up = timer_run && expire && !end_user;

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    player_d = player_q;
    lives_d  = lives_q;
    won_d    = won_q;
    mode_d   = mode_q;
    fail     = 1'b0;

    case (state_q)
      StInit: state_d = StSetup;
      StSetup: begin
        mode_d = practice;
        if (enter) begin
          state_d  = StPlayFpga;
          round_d  = ROUND_W'(1);
          player_d = '0;
          lives_d  = LIFE_W'(MAX_LIVES);
        end
      end
      StPlayFpga: if (end_fpga) state_d = StPlayUser;
      StPlayUser: begin
        if (end_user) begin
          state_d = StCheck;
        end else if (expire) begin
          fail = 1'b1;
        end
      end
      StCheck: begin
        if (match) begin
          state_d = StNextRound;
        end else begin
          fail = 1'b1;
        end
      end
      StNextRound: begin
        if (round_q == ROUND_W'(MAX_ROUNDS)) begin
          won_d   = 1'b1;
          state_d = StResult;
        end else begin
          round_d  = round_q + ROUND_W'(1);
          player_d = (player_q == PLAYER_W'(N_PLAYERS - 1)) ? '0 : player_q + PLAYER_W'(1);
          state_d  = StPlayFpga;
        end
      end
      StRetry:  state_d = StPlayFpga;
      StResult: if (enter) state_d = StInit;
      default:  state_d = StInit;
    endcase

    // Shared fail path for mismatch and timeout; lives only hit 0 on the way out
    if (fail) begin
      if (mode_q) begin
        state_d = StRetry;
      end else if (lives_q > LIFE_W'(1)) begin
        lives_d = lives_q - LIFE_W'(1);
        state_d = StRetry;
      end else begin
        lives_d = '0;
        won_d   = 1'b0;
        state_d = StResult;
      end
    end
  end

  always_ff @(posedge clock_50) begin
    if (!reset) begin
      state_q  <= StInit;
      round_q  <= '0;
      player_q <= '0;
      lives_q  <= LIFE_W'(MAX_LIVES);
      won_q    <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      player_q <= player_d;
      lives_q  <= lives_d;
      won_q    <= won_d;
      mode_q   <= mode_d;
    end
  end

  always_comb begin
    {r1, r2, e1, e2, e3, e4, sel} = 7'b0;
    case (state_q)
      StInit:      {r1, r2} = 2'b11;
      StSetup:     e1 = 1'b1;
      StPlayFpga:  e3 = 1'b1;
      StPlayUser:  e2 = 1'b1;
      StCheck:     e4 = 1'b1;
      StNextRound: r2 = 1'b1;
      StRetry:     r2 = 1'b1;
      StResult:    sel = 1'b1;
      default:     {r1, r2} = 2'b11;
    endcase
  end

  assign round  = round_q;
  assign player = player_q;
  assign lives  = lives_q;
  assign won    = won_q;

endmodule

// File: tb/tb_genius_controle.sv
module tb_genius_controle;

  // Strobe patterns packed as {r1, r2, e1, e2, e3, e4, sel}
  localparam logic [6:0] SInit   = 7'b1100000;
  localparam logic [6:0] SSetup  = 7'b0010000;
  localparam logic [6:0] SFpga   = 7'b0000100;
  localparam logic [6:0] SUser   = 7'b0001000;
  localparam logic [6:0] SCheck  = 7'b0000010;
  localparam logic [6:0] SR2     = 7'b0100000;
  localparam logic [6:0] SResult = 7'b0000001;

  logic clock_50 = 1'b0;
  logic reset, enter, end_fpga, end_user, key, match, practice;
  logic r1, r2, e1, e2, e3, e4, sel;
  logic [2:0] round;
  logic [1:0] player;
  logic [1:0] lives;
  logic time_up, won;

  int errors = 0;
  int checks = 0;

  genius_controle #(
    .MAX_ROUNDS    (5),
    .N_PLAYERS     (3),
    .MAX_LIVES     (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock_50(clock_50),
    .reset   (reset),
    .enter   (enter),
    .end_fpga(end_fpga),
    .end_user(end_user),
    .key     (key),
    .match   (match),
    .practice(practice),
    .r1      (r1),
    .r2      (r2),
    .e1      (e1),
    .e2      (e2),
    .e3      (e3),
    .e4      (e4),
    .sel     (sel),
    .round   (round),
    .player  (player),
    .lives   (lives),
    .time_up (time_up),
    .won     (won)
  );

  always #5 clock_50 = ~clock_50;

  task automatic tick();
    @(posedge clock_50);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {r1, r2, e1, e2, e3, e4, sel};
  endfunction

  // From PLAY_FPGA: playback, full entry, check with match=m; ends in the decision state
  task automatic play_round(input logic m, input logic [6:0] exp_dec);
    end_fpga = 1'b1;
    tick();
    end_fpga = 1'b0;
    chk("play_user", 32'(strobes()), 32'(SUser));
    end_user = 1'b1;
    tick();
    end_user = 1'b0;
    chk("check", 32'(strobes()), 32'(SCheck));
    match = m;
    tick();
    match = 1'b0;
    chk("decide", 32'(strobes()), 32'(exp_dec));
  endtask

  initial begin
    logic [1:0] exp_player [5];
    exp_player = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

    reset = 1'b0; enter = 1'b0; end_fpga = 1'b0; end_user = 1'b0;
    key = 1'b0; match = 1'b0; practice = 1'b0;
    tick();
    tick();
    chk("rst_strobes", 32'(strobes()), 32'(SInit));
    chk("rst_round", 32'(round), 32'd0);
    chk("rst_player", 32'(player), 32'd0);
    chk("rst_lives", 32'(lives), 32'd2);
    chk("rst_won", 32'(won), 32'd0);
    chk("rst_time_up", 32'(time_up), 32'd0);

    // Game A: five correct rounds, players rotate, win
    reset = 1'b1;
    tick();
    chk("setup", 32'(strobes()), 32'(SSetup));
    enter = 1'b1;
    tick();
    enter = 1'b0;
    chk("a_fpga", 32'(strobes()), 32'(SFpga));
    for (int i = 0; i < 5; i++) begin
      chk("a_round", 32'(round), 32'(i + 1));
      chk("a_player", 32'(player), 32'(exp_player[i]));
      play_round(1'b1, SR2);
      tick();
      chk("a_after_next", 32'(strobes()), 32'((i == 4) ? SResult : SFpga));
    end
    chk("a_won", 32'(won), 32'd1);
    chk("a_round_final", 32'(round), 32'd5);
    chk("a_lives", 32'(lives), 32'd2);

    // Held enter: RESULT -> INIT -> SETUP -> PLAY_FPGA
    enter = 1'b1;
    tick();
    chk("restart_init", 32'(strobes()), 32'(SInit));
    tick();
    chk("restart_setup", 32'(strobes()), 32'(SSetup));
    tick();
    enter = 1'b0;
    chk("restart_fpga", 32'(strobes()), 32'(SFpga));
    chk("restart_round", 32'(round), 32'd1);
    chk("restart_player", 32'(player), 32'd0);
    chk("restart_lives", 32'(lives), 32'd2);

    // Game B: timeout with no key fires 8 cycles after the entry edge
    end_fpga = 1'b1;
    tick();
    end_fpga = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk("b_time_up", 32'(time_up), 32'(c == 8));
      tick();
    end
    chk("b_retry", 32'(strobes()), 32'(SR2));
    chk("b_lives", 32'(lives), 32'd1);
    chk("b_time_up_gone", 32'(time_up), 32'd0);
    tick();
    chk("b_fpga", 32'(strobes()), 32'(SFpga));
    play_round(1'b0, SResult);
    chk("b_lost_lives", 32'(lives), 32'd0);
    chk("b_lost_won", 32'(won), 32'd0);
    chk("b_lost_round", 32'(round), 32'd1);

    enter = 1'b1;
    tick();
    tick();
    tick();
    enter = 1'b0;
    chk("c_fpga", 32'(strobes()), 32'(SFpga));

    // Game C: key on cycle 5 pushes expiry to cycle 13
    end_fpga = 1'b1;
    tick();
    end_fpga = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      key = (c == 5);
      #1;
      chk("c_time_up", 32'(time_up), 32'(c == 13));
      tick();
    end
    key = 1'b0;
    chk("c_retry", 32'(strobes()), 32'(SR2));
    chk("c_lives", 32'(lives), 32'd1);
    tick();

    // end_user together with expiry: CHECK wins, no time_up
    end_fpga = 1'b1;
    tick();
    end_fpga = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    end_user = 1'b1;
    #1;
    chk("c_tie_time_up", 32'(time_up), 32'd0);
    tick();
    end_user = 1'b0;
    chk("c_tie_check", 32'(strobes()), 32'(SCheck));
    chk("c_tie_lives", 32'(lives), 32'd1);
    match = 1'b1;
    tick();
    match = 1'b0;
    tick();
    chk("c_round2", 32'(round), 32'd2);
    chk("c_player1", 32'(player), 32'd1);

    // Reset during PLAY_USER with end_user high
    end_fpga = 1'b1;
    tick();
    end_fpga = 1'b0;
    chk("c_user", 32'(strobes()), 32'(SUser));
    reset = 1'b0;
    end_user = 1'b1;
    tick();
    reset = 1'b1;
    end_user = 1'b0;
    chk("mid_rst_strobes", 32'(strobes()), 32'(SInit));
    chk("mid_rst_round", 32'(round), 32'd0);
    chk("mid_rst_player", 32'(player), 32'd0);
    chk("mid_rst_lives", 32'(lives), 32'd2);
    tick();
    chk("mid_rst_setup", 32'(strobes()), 32'(SSetup));

    // Game D: practice mode, mismatches never cost lives
    practice = 1'b1;
    enter = 1'b1;
    tick();
    practice = 1'b0;
    enter = 1'b0;
    for (int i = 0; i < 5; i++) begin
      play_round(1'b0, SR2);
      chk("d_lives", 32'(lives), 32'd2);
      tick();
      chk("d_fpga", 32'(strobes()), 32'(SFpga));
    end
    chk("d_round", 32'(round), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/genius_controle.md
# genius_controle

Parametrised successor to the Genius game controller FSM. It sequences one game as SETUP → FPGA plays the sequence → user repeats it → check → next round → result. Round counting, user-response timeout, lives, practice mode and multiplayer turn rotation now live inside the block, so the datapath no longer supplies `win` or `end_time`. It drives the same enable/reset strobes (`r1`, `r2`, `e1`–`e4`, `sel`) to the existing sequence, user-input and display datapaths.

## Interface
- `MAX_ROUNDS`, 32: round at which a correct answer wins the game; must be ≥1.
- `N_PLAYERS`, 1: number of players taking turns round by round; must be ≥1.
- `MAX_LIVES`, 3: mismatches or timeouts allowed in normal mode; must be ≥1.
- `TIMEOUT_CYCLES`, 250_000_000: idle cycles allowed between user keys; must be ≥2.
- Derived (localparam): `ROUND_W = $clog2(MAX_ROUNDS+1)`, `PLAYER_W = max(1,$clog2(N_PLAYERS))`, `LIFE_W = $clog2(MAX_LIVES+1)`.

Ports:
- `clock_50` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `enter` in 1: start in SETUP; restart from RESULT.
- `end_fpga` in 1: sequence playback finished.
- `end_user` in 1: user has entered the full sequence for this round.
- `key` in 1: one-cycle pulse on any user key; restarts the timeout.
- `match` in 1: result of the datapath comparison, valid in CHECK.
- `practice` in 1: mode select; sampled only in SETUP.
- `r1`, `r2`, `e1`, `e2`, `e3`, `e4`, `sel` out 1: Moore decodes of the state.
- `round` out ROUND_W: current round number (1..MAX_ROUNDS during play).
- `player` out PLAYER_W: index of the active player.
- `lives` out LIFE_W: lives remaining.
- `time_up` out 1: one-cycle pulse when the timeout expires.
- `won` out 1: valid in RESULT; 1 = win, 0 = loss.

## Operation
States (3-bit): INIT, SETUP, PLAY_FPGA, PLAY_USER, CHECK, NEXT_ROUND, RETRY, RESULT.

Strobe decode (all other strobes 0):
- INIT: `r1` = `r2` = 1.
- SETUP: `e1`.
- PLAY_FPGA: `e3`.
- PLAY_USER: `e2`.
- CHECK: `e4`.
- NEXT_ROUND: `r2`.
- RETRY: `r2`.
- RESULT: `sel`.

Transitions and register updates:
- INIT → SETUP unconditionally.
- SETUP:
  - Latches `practice` into `mode_q` every cycle.
  - On `enter` = 1: go to PLAY_FPGA, set `round` = 1, `player` = 0, `lives` = MAX_LIVES.
- PLAY_FPGA → PLAY_USER when `end_fpga`. The timer clears on this transition.
- PLAY_USER:
  - Timer increments every cycle and clears on `key`.
  - `end_user` → CHECK. This takes priority over expiry in the same cycle.
  - Otherwise, timer reaching TIMEOUT_CYCLES−1 → fail path. `time_up` pulses on that cycle.
- CHECK: `match` → NEXT_ROUND; else fail path.
- Fail path:
  - If `mode_q`: → RETRY, lives unchanged.
  - Else if `lives` > 1: decrement `lives` and → RETRY.
  - Else: `lives` ← 0, `won` ← 0, → RESULT.
- RETRY → PLAY_FPGA. Same round, same player.
- NEXT_ROUND:
  - If `round` == MAX_ROUNDS: `won` ← 1, → RESULT.
  - Else: `round`++, `player` ← (`player`+1) mod N_PLAYERS, → PLAY_FPGA.
  - Lives are shared across players.
- RESULT: holds. On `enter`, → INIT, which re-strobes `r1`/`r2` for a full restart.
- Unused encodings → INIT.

## Timing
- Reset values (`reset` = 0 at an edge):
  - State INIT, so `r1` = `r2` = 1 and all other strobes 0.
  - `round` = 0, `player` = 0, `lives` = MAX_LIVES, `won` = 0, `time_up` = 0, timer = 0, `mode_q` = 0.
- Reset wins over every other input in the same cycle, in any state. Reset mid-game is equivalent to power-up.
- Strobes are pure functions of the state register and change one cycle after the deciding input.
- INIT, CHECK, NEXT_ROUND and RETRY each last exactly one cycle.
- `enter` is level-sensitive. The RESULT → INIT → SETUP path takes 2 cycles, so a held `enter` starts a new game 3 cycles after leaving RESULT. Debouncing is external.
- Timeout latency: with no `key`, `time_up` fires exactly TIMEOUT_CYCLES cycles after entering PLAY_USER. A `key` on cycle k pushes expiry to k+TIMEOUT_CYCLES.
- `end_user` and expiry in the same cycle: CHECK is taken and `time_up` is suppressed.
- Counters never wrap:
  - `round` saturates at MAX_ROUNDS by construction.
  - `lives` is never decremented below 1 in place; it is set to 0 only when entering RESULT.
  - `player` wraps modulo N_PLAYERS. When N_PLAYERS = 1 it stays 0.

## Structure
- Package `genius_pkg`: state typedef and encodings, and a `clog2`-based width helper shared with the datapath.
- Sub-module `genius_timer`: clear/restart inputs and an expire pulse, parameterised by TIMEOUT_CYCLES. This is the only natural split.
- Everything else (FSM, round/player/lives registers, decode) stays in `genius_controle`.

## Test plan
- Reset, then `enter` with `practice` = 0, MAX_ROUNDS = 2, and `end_fpga`/`end_user`/`match` = 1 each round → strobes e1, e3, e2, e4, r2 in order; `round` goes 1 → 2; RESULT with `won` = 1 and `sel` = 1.
- MAX_LIVES = 2, `match` = 0 twice → RETRY with `lives` = 1, then RESULT with `lives` = 0 and `won` = 0; `round` stays 1.
- TIMEOUT_CYCLES = 8, no `key` in PLAY_USER → `time_up` pulse 8 cycles after entry, then RETRY; with a `key` at cycle 5 → expiry at cycle 13.
- `practice` = 1, five mismatches → `lives` stays MAX_LIVES, RETRY each time, RESULT never reached.
- N_PLAYERS = 3, four correct rounds → `player` sequence 0, 1, 2, 0, 1.
- `reset` = 0 during PLAY_USER with `end_user` = 1 → next state INIT, `round` = 0, `r1` = `r2` = 1; RESULT + `enter` → INIT, then SETUP.
